// File: rtl/sequencia_checker_pkg.sv
// Shared types and constants for the triangle sequence generator and its checker.
// Holds the FSM state encoding, the default sample width and the MAX helper.
package sequencia_pkg;

    localparam int SEQ_WIDTH = 4;

    typedef enum logic [2:0] {
        SYNC,
        UP,
        TOP,
        DOWN,
        BOTTOM
    } estado_t;

    function automatic int seq_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/sequencia_checker_if.sv
// Observation bus between the sequence source (master) and the checker (slave).
// Carries the sample, its qualifier and all checker status outputs.
interface sequencia_checker_if #(
    parameter int WIDTH = sequencia_pkg::SEQ_WIDTH,
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
);
    logic             en;
    logic [WIDTH-1:0] sequencia;
    logic             locked;
    logic             sentido;
    logic [CNT_W-1:0] periodos;
    logic             erro;
    logic [ERR_W-1:0] erros;

    modport master (
        output en, sequencia,
        input  locked, sentido, periodos, erro, erros
    );

    modport slave (
        input  en, sequencia,
        output locked, sentido, periodos, erro, erros
    );
endinterface

// File: rtl/sequencia_checker_contador_sat.sv
// Up-counter that either wraps or saturates at all-ones (SAT selects).
// Registered output, increments on the edge where inc is high.
module contador_sat #(
    parameter int W   = 8,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && !(SAT && (&q))) begin
            q <= q + W'(1);
        end
    end
endmodule

// File: rtl/sequencia_checker.sv
// Checker for the up/down triangle sequence: lock, direction, periods, errors.
// One-cycle registered latency; en=0 freezes everything. Error counter built with SEQ_CHECKER_ERRCNT_EN.
module sequencia_checker
    import sequencia_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input logic               clk,
    input logic               rst,
    sequencia_checker_if.slave bus
);
    localparam int             MAXV  = seq_max(WIDTH);
    localparam logic [WIDTH:0] MAX_X = MAXV[WIDTH:0];

    estado_t          state;
    estado_t          nxt;
    logic [WIDTH-1:0] prev;

    // One extra bit so prev+1 at MAX and prev-1 at 0 can never equal a sample.
    logic [WIDTH:0] s_x, prev_x, inc_x, dec_x;
    logic           step_up, step_dn, same, s_max, s_zero;
    logic           ok, mism, per_inc;

    assign s_x     = {1'b0, bus.sequencia};
    assign prev_x  = {1'b0, prev};
    assign inc_x   = prev_x + (WIDTH+1)'(1);
    assign dec_x   = prev_x - (WIDTH+1)'(1);
    assign step_up = (s_x == inc_x);
    assign step_dn = (s_x == dec_x);
    assign same    = (s_x == prev_x);
    assign s_max   = (s_x == MAX_X);
    assign s_zero  = (s_x == '0);

    always_comb begin
        nxt = state;
        ok  = 1'b1;
        case (state)
            SYNC: begin
                if (step_up)              nxt = s_max ? TOP : UP;
                else if (step_dn)         nxt = s_zero ? BOTTOM : DOWN;
                else if (same && s_max)   nxt = DOWN;
                else if (same && s_zero)  nxt = UP;
            end
            UP: begin
                ok  = step_up;
                nxt = s_max ? TOP : UP;
            end
            TOP: begin
                ok  = s_max;
                nxt = DOWN;
            end
            DOWN: begin
                ok  = step_dn;
                nxt = s_zero ? BOTTOM : DOWN;
            end
            BOTTOM: begin
                ok  = s_zero;
                nxt = UP;
            end
            default: nxt = SYNC;
        endcase
        if (!ok) nxt = SYNC;
    end

    assign mism    = bus.en && !ok;
    assign per_inc = bus.en && (state == BOTTOM) && s_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SYNC;
            prev        <= '0;
            bus.locked  <= 1'b0;
            bus.sentido <= 1'b0;
            bus.erro    <= 1'b0;
        end else begin
            bus.erro <= mism;
            if (bus.en) begin
                prev       <= bus.sequencia;
                state      <= nxt;
                bus.locked <= (nxt != SYNC);
                // Direction is only meaningful while tracking; SYNC keeps the last one.
                if (nxt != SYNC) bus.sentido <= (nxt == TOP) || (nxt == DOWN);
            end
        end
    end

    contador_sat #(.W(CNT_W), .SAT(1'b0)) u_periodos (
        .clk (clk),
        .rst (rst),
        .inc (per_inc),
        .q   (bus.periodos)
    );

`ifdef SEQ_CHECKER_ERRCNT_EN
    contador_sat #(.W(ERR_W), .SAT(1'b1)) u_erros (
        .clk (clk),
        .rst (rst),
        .inc (mism),
        .q   (bus.erros)
    );
`else
    assign bus.erros = '0;
`endif

endmodule

// File: tb/tb_sequencia_checker.sv
// Bench for sequencia_checker: clean generator run, then a vector table of glitches,
// enable gating, error saturation and reacquisition around an asynchronous reset.
module tb_sequencia_checker;
    import sequencia_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 16;
    localparam int ERR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sequencia_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

    sequencia_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic             en;
        logic [WIDTH-1:0] seq;
        logic             locked;
        logic             sentido;
        int               periodos;
        logic             erro;
        int               nerr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   split;

    function automatic vec_t mk(logic en, int seq, logic lk, logic sd, int per, logic er, int ne);
        vec_t v;
        v.en = en; v.seq = WIDTH'(seq); v.locked = lk; v.sentido = sd;
        v.periodos = per; v.erro = er; v.nerr = ne;
        return v;
    endfunction

    function automatic int exp_erros(int n);
`ifdef SEQ_CHECKER_ERRCNT_EN
        int sat = (1 << ERR_W) - 1;
        return (n > sat) ? sat : n;
`else
        return 0;
`endif
    endfunction

    task automatic compare(string name, vec_t e);
        n_vec++;
        if (bus.locked !== e.locked || bus.sentido !== e.sentido ||
            bus.periodos !== CNT_W'(e.periodos) || bus.erro !== e.erro ||
            bus.erros !== ERR_W'(exp_erros(e.nerr))) begin
            n_bad++;
            $display("FAIL %s: got locked=%0b sentido=%0b periodos=%0d erro=%0b erros=%0d, want locked=%0b sentido=%0b periodos=%0d erro=%0b erros=%0d",
                     name, bus.locked, bus.sentido, bus.periodos, bus.erro, bus.erros,
                     e.locked, e.sentido, e.periodos, e.erro, exp_erros(e.nerr));
        end
    endtask

    task automatic step(string name, vec_t v);
        vec_t e;
        @(negedge clk);
        bus.en        = v.en;
        bus.sequencia = v.seq;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare(name, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, val;
        // Glitch on the rising ramp, then relock (continues from sample 4 of period 4).
        tbl.push_back(mk(1, 5, 1, 0, 3, 0, 0));
        tbl.push_back(mk(1, 6, 1, 0, 3, 0, 0));
        tbl.push_back(mk(1, 7, 1, 0, 3, 0, 0));
        tbl.push_back(mk(1, 9, 0, 0, 3, 1, 1));
        tbl.push_back(mk(1, 10, 1, 0, 3, 0, 1));
        for (int v = 11; v <= 14; v++) tbl.push_back(mk(1, v, 1, 0, 3, 0, 1));
        // Missing top hold, relock falling.
        tbl.push_back(mk(1, 15, 1, 1, 3, 0, 1));
        tbl.push_back(mk(1, 14, 0, 1, 3, 1, 2));
        tbl.push_back(mk(1, 13, 1, 1, 3, 0, 2));
        // Enable gating with arbitrary data.
        tbl.push_back(mk(0, 0, 1, 1, 3, 0, 2));
        tbl.push_back(mk(0, 15, 1, 1, 3, 0, 2));
        tbl.push_back(mk(0, 3, 1, 1, 3, 0, 2));
        tbl.push_back(mk(0, 7, 1, 1, 3, 0, 2));
        tbl.push_back(mk(0, 12, 1, 1, 3, 0, 2));
        tbl.push_back(mk(1, 12, 1, 1, 3, 0, 2));
        tbl.push_back(mk(1, 11, 1, 1, 3, 0, 2));
        // Drive errors past saturation.
        tbl.push_back(mk(1, 5, 0, 1, 3, 1, 3));
        tbl.push_back(mk(1, 6, 1, 0, 3, 0, 3));
        tbl.push_back(mk(1, 3, 0, 0, 3, 1, 4));
        tbl.push_back(mk(1, 4, 1, 0, 3, 0, 4));
        tbl.push_back(mk(1, 9, 0, 0, 3, 1, 5));
        tbl.push_back(mk(1, 10, 1, 0, 3, 0, 5));
        tbl.push_back(mk(1, 11, 1, 0, 3, 0, 5));
        split = tbl.size();
        // After reset: mid-sequence start, bottom hold, no-wrap, top-equal and bottom-equal locks.
        tbl.push_back(mk(1, 10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(1, 15, 0, 0, 1, 1, 2));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 2));
        tbl.push_back(mk(1, 15, 0, 0, 1, 0, 2));
        tbl.push_back(mk(1, 15, 1, 1, 1, 0, 2));
        tbl.push_back(mk(1, 14, 1, 1, 1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 3));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 3));
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 3));

        bus.en = 1'b0;
        bus.sequencia = '0;
        #2;
        compare("reset_state", mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;

        // Clean generator: 1..15,15,14..0,0 repeating; one period per 32 samples.
        for (int k = 1; k <= 100; k++) begin
            p = k % 32;
            if (p == 0)       val = 0;
            else if (p <= 15) val = p;
            else if (p == 16) val = 15;
            else              val = 31 - p;
            step($sformatf("clean_k%0d", k),
                 mk(1, val, 1, (p >= 15 && p <= 30), k / 32, 0, 0));
        end

        for (int i = 0; i < split; i++) step($sformatf("vec%0d", i), tbl[i]);

        // Asynchronous reset in the middle of a low clock phase.
        @(negedge clk);
        bus.en = 1'b0;
        #2 rst = 1'b0;
        #1;
        compare("async_rst", mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = split; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
